// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared states, key codes and matrix key map for the keypad scanner
package keypad_pkg;

   typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

   localparam logic [3:0] KEY_NONE    = 4'hF;
   localparam logic [3:0] KEY_START   = 4'hA;
   localparam logic [3:0] KEY_CLEAR   = 4'hB;
   localparam logic [3:0] KEY_CONFIRM = 4'hC;
   localparam logic [3:0] KEY_BLANK   = 4'hD;

   // '#' (row 3, column 2) maps to KEY_NONE so it can never be reported
   function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
      logic [3:0] k;
      case ({row, col})
         4'h0:    k = 4'h1;
         4'h1:    k = 4'h2;
         4'h2:    k = 4'h3;
         4'h3:    k = KEY_START;
         4'h4:    k = 4'h4;
         4'h5:    k = 4'h5;
         4'h6:    k = 4'h6;
         4'h7:    k = KEY_CLEAR;
         4'h8:    k = 4'h7;
         4'h9:    k = 4'h8;
         4'hA:    k = 4'h9;
         4'hB:    k = KEY_CONFIRM;
         4'hC:    k = 4'hE;
         4'hD:    k = 4'h0;
         4'hE:    k = KEY_NONE;
         default: k = KEY_BLANK;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// rtl/keypad_tick_gen.sv - scan-rate divider producing a one-clk tick strobe
module keypad_tick_gen #(
   parameter int CLK_DIV = 50000
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);
   localparam int CW = $clog2(CLK_DIV);

   logic [CW-1:0] cnt;

   assign tick = (cnt == CW'(CLK_DIV - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (tick)
         cnt <= '0;
      else
         cnt <= cnt + CW'(1);
   end

endmodule

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 keypad column scanner with press/release debounce
// Optional auto-repeat of key_valid while held: define KEYPAD_REPEAT_EN.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int CLK_DIV        = 50000,
   parameter int DEBOUNCE_TICKS = 20,
   parameter int REPEAT_TICKS   = 500
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] row_in,
   output logic [3:0] col_out,
   output logic [3:0] key_code,
   output logic       key_valid
);
   localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_TICKS);

   state_t     state, state_nxt;
   logic [3:0] row_meta, row_s;
   logic [1:0] col, col_nxt, lrow, lrow_nxt, row_idx;
   logic [7:0] dbc, dbc_nxt;
   logic [3:0] code_nxt;
   logic       valid_nxt, row_single, tick;
`ifdef KEYPAD_REPEAT_EN
   localparam int            RW       = $clog2(REPEAT_TICKS + 1);
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS);
   logic [RW-1:0] rep, rep_nxt, rep_inc;
   assign rep_inc = rep + RW'(1);
`endif

   keypad_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_meta <= 4'hF;
         row_s    <= 4'hF;
      end else begin
         row_meta <= row_in;
         row_s    <= row_meta;
      end
   end

   // Only a single low row counts as a key; ghosting/multi-press reads as nothing
   always_comb begin
      row_single = 1'b1;
      row_idx    = 2'd0;
      case (row_s)
         4'b1110: row_idx = 2'd0;
         4'b1101: row_idx = 2'd1;
         4'b1011: row_idx = 2'd2;
         4'b0111: row_idx = 2'd3;
         default: row_single = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= SCAN;
         col       <= 2'd0;
         lrow      <= 2'd0;
         dbc       <= '0;
         key_code  <= KEY_NONE;
         key_valid <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rep       <= '0;
`endif
      end else begin
         state     <= state_nxt;
         col       <= col_nxt;
         lrow      <= lrow_nxt;
         dbc       <= dbc_nxt;
         key_code  <= code_nxt;
         key_valid <= valid_nxt;
`ifdef KEYPAD_REPEAT_EN
         rep       <= rep_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt = state;
      col_nxt   = col;
      lrow_nxt  = lrow;
      dbc_nxt   = dbc;
      code_nxt  = key_code;
      valid_nxt = 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_nxt   = rep;
`endif
      if (tick) begin
         case (state)
            SCAN: begin
               if (row_single) begin
                  lrow_nxt  = row_idx;
                  dbc_nxt   = '0;
                  state_nxt = DEBOUNCE;
               end else begin
                  col_nxt = col + 2'd1;
               end
            end
            DEBOUNCE: begin
               if (row_single && row_idx == lrow) begin
                  dbc_nxt = dbc + 8'd1;
                  if (dbc_nxt == DB_LAST) begin
                     code_nxt  = key_map(lrow, col);
                     valid_nxt = (code_nxt != KEY_NONE);
                     state_nxt = HELD;
`ifdef KEYPAD_REPEAT_EN
                     rep_nxt   = '0;
`endif
                  end
               end else begin
                  state_nxt = SCAN;
                  col_nxt   = col + 2'd1;
               end
            end
            HELD: begin
               if (row_s[lrow]) begin
                  dbc_nxt   = '0;
                  state_nxt = RELEASE;
`ifdef KEYPAD_REPEAT_EN
                  rep_nxt   = '0;
               end else if (key_code != KEY_NONE) begin
                  if (rep_inc == REP_LAST) begin
                     valid_nxt = 1'b1;
                     rep_nxt   = '0;
                  end else begin
                     rep_nxt = rep_inc;
                  end
`endif
               end
            end
            default: begin
               if (row_s == 4'hF) begin
                  dbc_nxt = dbc + 8'd1;
                  if (dbc_nxt == DB_LAST) begin
                     code_nxt  = KEY_NONE;
                     state_nxt = SCAN;
                     col_nxt   = col + 2'd1;
                  end
               end else if (!row_s[lrow]) begin
                  state_nxt = HELD;
               end else begin
                  dbc_nxt = '0;
               end
            end
         endcase
      end
   end

   always_comb begin
      col_out = ~(4'b0001 << col);
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - self-checking bench for keypad_scanner against a tick-level key model
module tb_keypad_scanner;
   localparam int CLK_DIV = 4;
   localparam int DT      = 4;
   localparam int RT      = 10;
`ifdef KEYPAD_REPEAT_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] row_in;
   logic [3:0] col_out, key_code;
   logic       key_valid;
   logic [15:0] keys = '0;

   int n_checks = 0;
   int n_fail   = 0;
   int pulses   = 0;

   keypad_scanner #(.CLK_DIV(CLK_DIV), .DEBOUNCE_TICKS(DT), .REPEAT_TICKS(RT)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .row_in    (row_in),
      .col_out   (col_out),
      .key_code  (key_code),
      .key_valid (key_valid)
   );

   always #5 clk = ~clk;

   // Physical keypad: a pressed key pulls its row low while its column is driven
   always_comb begin
      row_in = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
   end

   always @(negedge clk) if (key_valid) pulses <= pulses + 1;

   logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                             4'h7, 4'h8, 4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

   // Model: which column is searched, which row is locked, how many consecutive samples agree
   int         m_col, m_row, m_run, m_rep, n_clk;
   bit         m_lock, m_acc, m_rel;
   logic [3:0] m_code, d1, d2, cur;
   logic       m_valid;

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_col = 0; m_row = 0; m_run = 0; m_rep = 0; n_clk = 0;
      m_lock = 0; m_acc = 0; m_rel = 0;
      m_code = 4'hF; m_valid = 1'b0; d1 = 4'hF; d2 = 4'hF;
   endtask

   task automatic on_tick(input logic [3:0] r);
      int nz = 0;
      int idx = 0;
      for (int i = 0; i < 4; i++) if (!r[i]) begin nz++; idx = i; end
      if (!m_lock) begin
         if (nz == 1) begin m_lock = 1; m_row = idx; m_run = 0; end
         else m_col = (m_col + 1) % 4;
      end else if (!m_acc) begin
         if (nz == 1 && idx == m_row) begin
            m_run++;
            if (m_run == DT) begin
               m_acc = 1; m_rel = 0; m_rep = 0;
               m_code = kmap[m_row*4 + m_col];
               m_valid = (m_code != 4'hF);
            end
         end else begin
            m_lock = 0; m_col = (m_col + 1) % 4;
         end
      end else if (!m_rel) begin
         if (r[m_row]) begin m_rel = 1; m_run = 0; m_rep = 0; end
         else if (REP && m_code != 4'hF) begin
            m_rep++;
            if (m_rep == RT) begin m_valid = 1'b1; m_rep = 0; end
         end
      end else begin
         if (r == 4'hF) begin
            m_run++;
            if (m_run == DT) begin
               m_code = 4'hF; m_lock = 0; m_acc = 0; m_rel = 0;
               m_col = (m_col + 1) % 4;
            end
         end else if (!r[m_row]) m_rel = 0;
         else m_run = 0;
      end
   endtask

   task automatic model_loop();
      logic [3:0] use_rows;
      model_reset();
      cur = 4'hF;
      forever begin
         @(posedge clk);
         if (rst_n) begin
            use_rows = d2; d2 = d1; d1 = cur;
            m_valid = 1'b0;
            n_clk++;
            if (n_clk % CLK_DIV == 0) on_tick(use_rows);
         end
         @(negedge clk);
         if (!rst_n) model_reset();
         check("col_out", col_out, ~(4'b0001 << m_col));
         check("key_code", key_code, m_code);
         check("key_valid", {3'b000, key_valid}, {3'b000, m_valid});
         cur = row_in;
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic ticks(input int n);
      clks(n * CLK_DIV);
   endtask

   task automatic set_key(input int r, input int c, input bit v);
      keys[r*4+c] = v;
   endtask

   task automatic stimulus();
      int base;
      int t;
      clks(3);
      rst_n = 1'b1;
      check("rst_col", col_out, 4'b1110);
      check("rst_code", key_code, 4'hF);
      check("rst_valid", {3'b000, key_valid}, 4'h0);
      ticks(1);
      check("col_after_tick", col_out, 4'b1101);
      ticks(7);
      check("idle_code", key_code, 4'hF);
      check("idle_pulses", 4'(pulses), 4'h0);

      base = pulses;
      set_key(1, 2, 1);
      ticks(12);
      check("key6_code", key_code, 4'h6);
      check("key6_model", m_code, 4'h6);
      check("key6_pulses", 4'(pulses - base), 4'h1);
      set_key(1, 2, 0);
      ticks(8);
      check("key6_release", key_code, 4'hF);
      check("key6_pulses_rel", 4'(pulses - base), 4'h1);

      base = pulses;
      for (int b = 0; b < 3; b++) begin
         set_key(0, 3, 1); ticks(2);
         set_key(0, 3, 0); ticks(2);
      end
      check("bounce_no_pulse", 4'(pulses - base), 4'h0);
      set_key(0, 3, 1);
      ticks(12);
      check("keyA_code", key_code, 4'hA);
      check("keyA_pulses", 4'(pulses - base), 4'h1);
      set_key(0, 3, 0);
      ticks(10);

      base = pulses;
      set_key(0, 1, 1); set_key(2, 1, 1);
      ticks(12);
      check("ghost_code", key_code, 4'hF);
      check("ghost_pulses", 4'(pulses - base), 4'h0);
      set_key(0, 1, 0); set_key(2, 1, 0);
      ticks(4);
      set_key(3, 2, 1);
      ticks(12);
      check("hash_code", key_code, 4'hF);
      check("hash_pulses", 4'(pulses - base), 4'h0);
      set_key(3, 2, 0);
      ticks(10);

      base = pulses;
      set_key(0, 0, 1);
      ticks(12);
      check("key1_code", key_code, 4'h1);
      set_key(2, 2, 1);
      ticks(6);
      check("key1_wins", key_code, 4'h1);
      set_key(0, 0, 0);
      ticks(16);
      check("key9_code", key_code, 4'h9);
      check("key19_pulses", 4'(pulses - base), 4'h2);
      set_key(2, 2, 0);
      ticks(10);

      base = pulses;
      set_key(2, 3, 1);
      t = 0;
      while (!key_valid && t < 200) begin clks(1); t++; end
      check("keyC_timeout", {3'b000, t < 200}, 4'h1);
      ticks(35);
      check("keyC_code", key_code, 4'hC);
      check("keyC_pulses", 4'(pulses - base), REP ? 4'h4 : 4'h1);
      rst_n = 1'b0;
      #1;
      check("midrst_col", col_out, 4'b1110);
      check("midrst_code", key_code, 4'hF);
      check("midrst_valid", {3'b000, key_valid}, 4'h0);
      clks(2);
      rst_n = 1'b1;
      ticks(12);
      check("keyC_redetect", key_code, 4'hC);
      set_key(2, 3, 0);
      ticks(8);
      check("keyC_release", key_code, 4'hF);
   endtask

   initial begin
      fork
         model_loop();
         stimulus();
      join_any
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
